// File: rtl/fw_verifier_if.sv
// fw_verifier_if
//   Read-only boot ROM bus used by the firmware verifier.
//   mem_valid : read request, held with mem_addr until mem_ready
//   mem_addr  : word-aligned byte address of the request
//   mem_rdata : read data, meaningful while mem_ready=1
//   mem_ready : read completion, may assert in the same cycle as mem_valid
//   master modport is the verifier side, slave modport is the ROM side.
interface fw_verifier_if;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_valid,
        output mem_addr,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_valid,
        input  mem_addr,
        output mem_rdata,
        output mem_ready
    );
endinterface

// File: rtl/fw_verifier.sv
// fw_verifier
//   Walks a firmware image in boot ROM, folding every word except the last
//   into a rotate-and-XOR accumulator, then compares the final (checksum)
//   word against the accumulator. A per-word wait counter aborts the run
//   if the ROM never answers.
// Ports
//   clk      : sole clock, rising edge
//   reset    : synchronous, active-high; wins over start
//   start    : single-cycle request to begin a run (only honoured in IDLE)
//   mem      : ROM read bus (master side)
//   busy     : high while not in IDLE
//   done     : one-cycle pulse at the end of a run
//   verified : last run's checksum matched (level)
//   error    : last run ended in timeout (level)
//   checksum : running/final accumulator value
module fw_verifier #(
    parameter int          WORDS     = 1155,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    fw_verifier_if.master        mem,
    output logic                 busy,
    output logic                 done,
    output logic                 verified,
    output logic                 error,
    output logic [31:0]          checksum
);

    localparam int IDX_W  = $clog2(WORDS);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(WORDS - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        GAP,
        DONE
    } state_t;

    state_t            state;
    logic [31:0]       acc;
    logic [IDX_W-1:0]  idx;
    logic [WAIT_W-1:0] wait_cnt;

    assign checksum = acc;

    // Single FSM process; every output is registered so the request is
    // presented in the same cycle the state shows READ.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            acc           <= '0;
            idx           <= '0;
            wait_cnt      <= '0;
            mem.mem_valid <= 1'b0;
            mem.mem_addr  <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            verified      <= 1'b0;
            error         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        acc           <= '0;
                        idx           <= '0;
                        wait_cnt      <= '0;
                        verified      <= 1'b0;
                        error         <= 1'b0;
                        mem.mem_valid <= 1'b1;
                        mem.mem_addr  <= BASE_ADDR;
                        busy          <= 1'b1;
                        state         <= READ;
                    end
                end

                READ: begin
                    if (mem.mem_ready) begin
                        wait_cnt      <= '0;
                        mem.mem_valid <= 1'b0;
                        if (idx == LAST_IDX) begin
                            // Last word is the stored checksum, not folded in.
                            verified <= (mem.mem_rdata == acc);
                            done     <= 1'b1;
                            state    <= DONE;
                        end else begin
                            acc   <= {acc[30:0], acc[31]} ^ mem.mem_rdata;
                            idx   <= idx + 1'b1;
                            state <= GAP;
                        end
                    end else if (wait_cnt == WAIT_LAST) begin
                        // This stalled cycle is the TIMEOUT-th one.
                        error         <= 1'b1;
                        verified      <= 1'b0;
                        done          <= 1'b1;
                        mem.mem_valid <= 1'b0;
                        state         <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                GAP: begin
                    // idx already points at the next word; address wraps at 32 bits.
                    mem.mem_valid <= 1'b1;
                    mem.mem_addr  <= BASE_ADDR + (32'(idx) << 2);
                    wait_cnt      <= '0;
                    state         <= READ;
                end

                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    mem.mem_valid <= 1'b0;
                    busy          <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fw_verifier.sv
// tb_fw_verifier
//   Scoreboard bench for fw_verifier with a 4-word image. Stimulus pushes
//   expected ROM addresses and the expected run result into queues; a
//   monitor pops and compares them whenever a read handshake or a done
//   pulse is observed. A ROM model answers requests with tied-high,
//   tied-low or randomly stalled ready.
module tb_fw_verifier;

    localparam int          W    = 4;
    localparam int          TO   = 5;
    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        busy;
    logic        done;
    logic        verified;
    logic        error;
    logic [31:0] checksum;

    fw_verifier_if mem_bus ();

    fw_verifier #(
        .WORDS     (W),
        .BASE_ADDR (BASE),
        .TIMEOUT   (TO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .mem      (mem_bus),
        .busy     (busy),
        .done     (done),
        .verified (verified),
        .error    (error),
        .checksum (checksum)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] sum;
        logic        ver;
        logic        err;
        int          lat;
        int          vc;
    } exp_t;

    logic [31:0] addr_q[$];
    exp_t        res_q[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int start_cyc = 0;
    int ready_mode = 0;
    logic [31:0] rom [W];

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // ROM model: drives ready/rdata just after each rising edge.
    // Mode 0 ready tied high, mode 1 tied low, mode 2 stalls 0-3 cycles per
    // request and toggles ready randomly while no request is open.
    int stall_tgt = 0;
    int stall_cnt = 0;
    always @(posedge clk) begin
        logic [31:0] off;
        #1;
        case (ready_mode)
            0: mem_bus.mem_ready = 1'b1;
            1: mem_bus.mem_ready = 1'b0;
            default: begin
                if (!mem_bus.mem_valid) begin
                    mem_bus.mem_ready = 1'($urandom_range(0, 1));
                    stall_tgt = $urandom_range(0, 3);
                    stall_cnt = 0;
                end else if (stall_cnt < stall_tgt) begin
                    mem_bus.mem_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    mem_bus.mem_ready = 1'b1;
                end
            end
        endcase
        off = mem_bus.mem_addr - BASE;
        mem_bus.mem_rdata = rom[off[3:2]];
    end

    // Monitor: compares every accepted request address and every done pulse
    // against the scoreboard queues; also checks address stability in stalls.
    // Latency is the 1-based cycle after the start-sampling edge in which
    // done is high.
    int          vcnt = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_addr = '0;
    always @(negedge clk) begin
        exp_t e;
        if (mem_bus.mem_valid) vcnt++;
        if (prev_stall && mem_bus.mem_valid)
            checkOutput("addr_stable", mem_bus.mem_addr, prev_addr);
        if (mem_bus.mem_valid && mem_bus.mem_ready) begin
            if (addr_q.size() == 0) checkOutput("unexpected_req", 32'd1, 32'd0);
            else checkOutput("req_addr", mem_bus.mem_addr, addr_q.pop_front());
        end
        if (done) begin
            if (res_q.size() == 0) begin
                checkOutput("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = res_q.pop_front();
                checkOutput("done_checksum", checksum, e.sum);
                checkOutput("done_verified", 32'(verified), 32'(e.ver));
                checkOutput("done_error", 32'(error), 32'(e.err));
                checkOutput("done_busy", 32'(busy), 32'd1);
                if (e.lat != 0) checkOutput("done_latency", 32'(cyc - start_cyc + 1), 32'(e.lat));
                if (e.vc != 0) checkOutput("valid_cycles", 32'(vcnt), 32'(e.vc));
            end
            vcnt = 0;
        end
        prev_stall = mem_bus.mem_valid && !mem_bus.mem_ready;
        prev_addr  = mem_bus.mem_addr;
        if (!busy) vcnt = 0;
    end

    task automatic loadRom(input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2, input logic [31:0] w3);
        rom[0] = w0;
        rom[1] = w1;
        rom[2] = w2;
        rom[3] = w3;
    endtask

    // One full run: queue expectations, pulse start, wait (bounded) for done,
    // then check the held levels in IDLE.
    task automatic applyStimulus(input int mode, input logic [31:0] exp_sum,
                                 input logic exp_ver, input logic exp_err,
                                 input int exp_lat, input int exp_vc,
                                 input bit extra_start);
        exp_t e;
        bit   got;
        ready_mode = mode;
        if (!exp_err)
            for (int i = 0; i < W; i++) addr_q.push_back(BASE + 32'(4 * i));
        e.sum = exp_sum;
        e.ver = exp_ver;
        e.err = exp_err;
        e.lat = exp_lat;
        e.vc  = exp_vc;
        res_q.push_back(e);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        start_cyc = cyc;
        if (extra_start) begin
            repeat (2) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        got = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        checkOutput("done_seen", 32'(got), 32'd1);
        @(negedge clk);
        checkOutput("idle_busy", 32'(busy), 32'd0);
        checkOutput("idle_done", 32'(done), 32'd0);
        checkOutput("idle_verified", 32'(verified), 32'(exp_ver));
        checkOutput("idle_error", 32'(error), 32'(exp_err));
        checkOutput("idle_checksum", checksum, exp_sum);
        checkOutput("addr_q_drained", 32'(addr_q.size()), 32'd0);
        addr_q.delete();
        res_q.delete();
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_valid"}, 32'(mem_bus.mem_valid), 32'd0);
        checkOutput({tag, "_addr"}, mem_bus.mem_addr, 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_verified"}, 32'(verified), 32'd0);
        checkOutput({tag, "_error"}, 32'(error), 32'd0);
        checkOutput({tag, "_checksum"}, checksum, 32'd0);
    endtask

    initial begin
        bit hit;
        reset = 1'b1;
        start = 1'b0;
        loadRom(32'd1, 32'd2, 32'd3, 32'd3);
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        reset = 1'b0;
        @(negedge clk);

        // Good image: acc 1 -> 0 -> 3, stored checksum 3.
        applyStimulus(0, 32'd3, 1'b1, 1'b0, 2 * W, W, 1'b0);

        // Bad stored checksum (4 vs 3).
        loadRom(32'd1, 32'd2, 32'd3, 32'd4);
        applyStimulus(0, 32'd3, 1'b0, 1'b0, 2 * W, W, 1'b0);

        // ROM never answers: valid held 5 cycles at BASE, done in cycle 6.
        loadRom(32'd1, 32'd2, 32'd3, 32'd3);
        applyStimulus(1, 32'd0, 1'b0, 1'b1, TO + 1, TO, 1'b0);

        // Random 0-3 cycle stalls; address must hold in each stall.
        applyStimulus(2, 32'd3, 1'b1, 1'b0, 0, 0, 1'b0);

        // Extra start while busy must not disturb result or timing.
        applyStimulus(0, 32'd3, 1'b1, 1'b0, 2 * W, W, 1'b1);

        // Rotate carries bit 31 into bit 0: 80000001 -> 00000013 -> FFFFFFD9.
        loadRom(32'h8000_0001, 32'h0000_0010, 32'hFFFF_FFFF, 32'hFFFF_FFD9);
        applyStimulus(0, 32'hFFFF_FFD9, 1'b1, 1'b0, 2 * W, W, 1'b0);

        // Reset mid-run while the third word (idx 2) is requested; acc is 12.
        loadRom(32'd5, 32'd6, 32'd7, 32'd0);
        ready_mode = 0;
        for (int i = 0; i < W; i++) addr_q.push_back(BASE + 32'(4 * i));
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (mem_bus.mem_valid && mem_bus.mem_addr == BASE + 32'd8) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checkOutput("reach_idx2", 32'(hit), 32'd1);
        checkOutput("mid_checksum", checksum, 32'd12);
        reset = 1'b1;
        @(negedge clk);
        addr_q.delete();
        res_q.delete();
        checkAllZero("midreset");
        reset = 1'b0;

        // Restart after reset begins again at BASE.
        loadRom(32'd1, 32'd2, 32'd3, 32'd3);
        applyStimulus(0, 32'd3, 1'b1, 1'b0, 2 * W, W, 1'b0);

        // Start coincident with reset: reset wins, nothing starts.
        @(negedge clk);
        start = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        checkAllZero("startreset");
        repeat (20) @(negedge clk);
        checkOutput("startreset_idle", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
